// File: rtl/serial_word_loader.sv
// serial_word_loader: deframes start/data(LSB-first)/parity/stop serial words into a parallel register load.
module serial_word_loader #(
  parameter int WIDTH     = 7,
  parameter bit PARITY_EN = 1'b1,
  parameter bit ODD_PAR   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             load,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;
  localparam logic [1:0] STOP = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
  logic             perr_q, perr_d, load_q, load_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    if (sin_valid) begin
      case (state_q)
        IDLE: if (!sin) begin
          state_d = DATA;
          cnt_d   = '0;
          perr_d  = 1'b0;
        end
        // shifting right leaves the first-received bit in sh[0] after WIDTH bits
        DATA: begin
          sh_d  = {sin, sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY_EN ? PAR : STOP;
        end
        PAR: begin
          perr_d  = (^sh_q ^ sin) != ODD_PAR;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (sin && !perr_q) begin
            dout_d = sh_q;
            load_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end
  assign dout = dout_q;
  assign load = load_q;
  assign err  = err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: table vectors, hand corner sequences and random frames against a frame-level model.
module tb_serial_word_loader;
  logic       clk = 1'b0, rst = 1'b0;
  logic       sin = 1'b1, sin_valid = 1'b0, sin1 = 1'b1, sv1 = 1'b0;
  logic [6:0] dout, dout1;
  logic       load, busy, err, load1, busy1, err1;
  int         checks = 0, failures = 0;
  int         nload, nerr, busy_bad, dout_bad = 0;
  logic [6:0] model_dout = '0;
  typedef struct {
    logic [6:0] d;
    logic       p, stop, gap, exp_load, exp_err;
    logic [6:0] exp_dout;
  } vec_t;
  vec_t tbl[7];
  always #5 clk = ~clk;
  serial_word_loader dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .dout(dout), .load(load), .busy(busy), .err(err)
  );
  serial_word_loader #(.WIDTH(7), .PARITY_EN(1'b0), .ODD_PAR(1'b0)) dut_np (
    .clk(clk), .rst(rst), .sin(sin1), .sin_valid(sv1),
    .dout(dout1), .load(load1), .busy(busy1), .err(err1)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic [6:0] prev;
    prev = dout;
    @(posedge clk);
    #1;
    if (dout !== prev && !load) dout_bad++;
    if (load) nload++;
    if (err) nerr++;
  endtask
  // drives one frame, optionally with an idle sin_valid=0 cycle after each bit but the stop bit
  task automatic send(input logic [6:0] d, input logic p, input logic stop, input logic gap, input string name);
    logic [9:0] fr;
    fr = {stop, p, d, 1'b0};
    nload = 0;
    nerr = 0;
    busy_bad = 0;
    for (int i = 0; i < 10; i++) begin
      sin = fr[i];
      sin_valid = 1'b1;
      tick();
      if (i < 9 && busy !== 1'b1) busy_bad++;
      if (gap && i < 9) begin
        sin_valid = 1'b0;
        sin = 1'($urandom);
        tick();
        if (busy !== 1'b1) busy_bad++;
      end
    end
    sin_valid = 1'b0;
    sin = 1'b1;
    check({name, "_busy_in_frame"}, busy_bad, 0);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_no_overlap"}, load & err, 0);
  endtask
  task automatic model(input logic [6:0] d, input logic p, input logic stop, output logic good);
    good = stop && ((^d ^ p) == 1'b0);
    if (good) model_dout = d;
  endtask
  initial begin
    logic good;
    logic [6:0] d;
    logic p, stop, gap;
    int ncnt, bcnt;
    logic [8:0] fr1;
    tbl[0] = '{7'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h55};
    tbl[1] = '{7'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h55};
    tbl[2] = '{7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h55};
    tbl[3] = '{7'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'h01};
    tbl[4] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00};
    tbl[5] = '{7'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'h7F};
    tbl[6] = '{7'h2A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'h2A};
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].d, tbl[i].p, tbl[i].stop, tbl[i].gap, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_load", i), nload, 32'(tbl[i].exp_load));
      check($sformatf("tbl%0d_err", i), nerr, 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
    end
    model_dout = 7'h2A;
    nload = 0;
    nerr = 0;
    for (int i = 0; i < 4; i++) begin
      sin = (i == 0) ? 1'b0 : 1'b1;
      sin_valid = 1'b1;
      tick();
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pulses", {load, err}, 0);
    tick();
    tick();
    rst = 1'b1;
    model_dout = '0;
    check("midrst_no_pulse_seen", nload + nerr, 0);
    send(7'h33, 1'b0, 1'b1, 1'b0, "after_rst");
    check("after_rst_load", nload, 1);
    check("after_rst_dout", dout, 7'h33);
    model_dout = 7'h33;
    fr1 = {1'b1, 7'h40, 1'b0};
    ncnt = 0;
    for (int i = 0; i < 9; i++) begin
      sin1 = fr1[i];
      sv1 = 1'b1;
      @(posedge clk);
      #1;
      if (load1) ncnt++;
    end
    check("np_load_at_9", load1, 1);
    check("np_load_count", ncnt, 1);
    check("np_dout", dout1, 7'h40);
    check("np_err", err1, 0);
    ncnt = 0;
    bcnt = 0;
    sin1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (load1 || err1) ncnt++;
      if (busy1) bcnt++;
    end
    sv1 = 1'b0;
    check("np_idle_pulses", ncnt, 0);
    check("np_idle_busy", bcnt, 0);
    for (int n = 0; n < 40; n++) begin
      d = 7'($urandom);
      p = ($urandom_range(0, 3) != 0) ? ^d : ~^d;
      stop = $urandom_range(0, 9) != 0;
      gap = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        sin = 1'b1;
        sin_valid = 1'b1;
        tick();
      end
      send(d, p, stop, gap, $sformatf("rnd%0d", n));
      model(d, p, stop, good);
      check($sformatf("rnd%0d_load", n), nload, 32'(good));
      check($sformatf("rnd%0d_err", n), nerr, 32'(!good));
      check($sformatf("rnd%0d_dout", n), dout, model_dout);
    end
    check("dout_only_with_load", dout_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
